// File: rtl/gcm_decrypt_stage.sv
`default_nettype none
// ============================================================================
// Module   : gcm_decrypt_stage
// Brief    : AES-GCM decrypt back end: CTR keystream XOR, bit-serial GHASH
//            over AAD/ciphertext/length blocks, and final tag generation.
//            Define GCM_TAG_CHECK_EN to add i_tag / o_auth_ok tag compare.
// Revision : 1.0 - initial release
// ============================================================================
module gcm_decrypt_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [0:2]   i_phase,
  input  logic [0:127] i_data,
  input  logic [0:15]  i_byte_en,
  input  logic [0:127] i_keystream,
  input  logic [0:127] i_h,
  input  logic [0:127] i_ek_j0,
`ifdef GCM_TAG_CHECK_EN
  input  logic [0:127] i_tag,
  output logic         o_auth_ok,
`endif
  output logic [0:127] o_data,
  output logic         o_data_valid,
  output logic [0:127] o_tag,
  output logic         o_tag_valid
);

  localparam logic [0:2]   c_phase_aad = 3'b000;
  localparam logic [0:2]   c_phase_txt = 3'b010;
  localparam logic [0:2]   c_phase_len = 3'b111;
  localparam logic [0:127] c_gf_poly   = {8'hE1, 120'h0};

  typedef enum logic [1:0] {ST_IDLE, ST_MULT, ST_TAG} state_t;

  state_t       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [0:127] y_q, y_d, x_q, x_d, z_q, z_d, v_q, v_d;
  logic [0:127] h_q, h_d, ek_q, ek_d;
  logic         first_q, first_d, is_len_q, is_len_d;
  logic [0:127] data_q, data_d, tag_q, tag_d;
  logic         data_valid_q, data_valid_d, tag_valid_q, tag_valid_d;

  logic [0:127] byte_mask, data_masked, y_base, z_step, v_step;
  logic         start;

  for (genvar k = 0; k < 16; k++) begin : g_byte_mask
    assign byte_mask[8*k +: 8] = {8{i_byte_en[k]}};
  end

  assign data_masked = i_data & byte_mask;
  assign start       = i_valid && (state_q == ST_IDLE) &&
                       ((i_phase == c_phase_aad) || (i_phase == c_phase_txt) ||
                        (i_phase == c_phase_len));
  assign y_base      = first_q ? '0 : y_q;
  // X is shifted toward index 0 each step so x_q[0] is always the current bit.
  assign z_step      = x_q[0] ? (z_q ^ v_q) : z_q;
  assign v_step      = v_q[127] ? ({1'b0, v_q[0:126]} ^ c_gf_poly) : {1'b0, v_q[0:126]};

`ifdef GCM_TAG_CHECK_EN
  logic [0:127] tag_ref_q, tag_ref_d;
  logic         auth_ok_q, auth_ok_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    y_d          = y_q;
    x_d          = x_q;
    z_d          = z_q;
    v_d          = v_q;
    h_d          = h_q;
    ek_d         = ek_q;
    first_d      = first_q;
    is_len_d     = is_len_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    tag_d        = tag_q;
    tag_valid_d  = 1'b0;
`ifdef GCM_TAG_CHECK_EN
    tag_ref_d    = tag_ref_q;
    auth_ok_d    = auth_ok_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (first_q) begin
            h_d  = i_h;
            ek_d = i_ek_j0;
          end
          y_d      = y_base;
          x_d      = y_base ^ data_masked;
          z_d      = '0;
          v_d      = first_q ? i_h : h_q;
          first_d  = 1'b0;
          is_len_d = (i_phase == c_phase_len);
          cnt_d    = 7'd0;
          state_d  = ST_MULT;
          if (i_phase == c_phase_txt) begin
            data_d       = (i_data ^ i_keystream) & byte_mask;
            data_valid_d = 1'b1;
          end
`ifdef GCM_TAG_CHECK_EN
          if (i_phase == c_phase_len) tag_ref_d = i_tag;
`endif
        end
      end
      ST_MULT: begin
        z_d   = z_step;
        v_d   = v_step;
        x_d   = {x_q[1:127], 1'b0};
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd127) begin
          y_d     = z_step;
          state_d = is_len_q ? ST_TAG : ST_IDLE;
          if (is_len_q) begin
            tag_d       = z_step ^ ek_q;
            tag_valid_d = 1'b1;
`ifdef GCM_TAG_CHECK_EN
            auth_ok_d   = ((z_step ^ ek_q) == tag_ref_q);
`endif
          end
        end
      end
      ST_TAG: begin
        first_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 7'd0;
      y_q          <= '0;
      x_q          <= '0;
      z_q          <= '0;
      v_q          <= '0;
      h_q          <= '0;
      ek_q         <= '0;
      first_q      <= 1'b1;
      is_len_q     <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      tag_q        <= '0;
      tag_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      y_q          <= y_d;
      x_q          <= x_d;
      z_q          <= z_d;
      v_q          <= v_d;
      h_q          <= h_d;
      ek_q         <= ek_d;
      first_q      <= first_d;
      is_len_q     <= is_len_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      tag_q        <= tag_d;
      tag_valid_q  <= tag_valid_d;
    end
  end

`ifdef GCM_TAG_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_ref_q <= '0;
      auth_ok_q <= 1'b0;
    end else begin
      tag_ref_q <= tag_ref_d;
      auth_ok_q <= auth_ok_d;
    end
  end
  assign o_auth_ok = auth_ok_q;
`endif

  assign o_ready      = (state_q == ST_IDLE);
  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_tag        = tag_q;
  assign o_tag_valid  = tag_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gcm_decrypt_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcm_decrypt_stage
// Brief    : Self-checking bench for gcm_decrypt_stage (NIST vectors, random
//            messages against a polynomial-arithmetic GHASH model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcm_decrypt_stage;

  localparam logic [0:2] P_AAD = 3'b000;
  localparam logic [0:2] P_TXT = 3'b010;
  localparam logic [0:2] P_LEN = 3'b111;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [0:2]   i_phase;
  logic [0:127] i_data, i_keystream, i_h, i_ek_j0, o_data, o_tag;
  logic [0:15]  i_byte_en;
  logic         o_data_valid, o_tag_valid;
`ifdef GCM_TAG_CHECK_EN
  logic [0:127] tb_tag;
  logic         o_auth_ok;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcm_decrypt_stage dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_phase      (i_phase),
    .i_data       (i_data),
    .i_byte_en    (i_byte_en),
    .i_keystream  (i_keystream),
    .i_h          (i_h),
    .i_ek_j0      (i_ek_j0),
`ifdef GCM_TAG_CHECK_EN
    .i_tag        (tb_tag),
    .o_auth_ok    (o_auth_ok),
`endif
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_tag        (o_tag),
    .o_tag_valid  (o_tag_valid)
  );

  // Reference model state: running GHASH, latched key material, held outputs.
  logic [0:127] m_y, m_h, m_ek, m_data, m_tag;
  bit           m_first;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // GF(2^128) product as polynomials: coefficient of x^i is block bit i.
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ar, br, r;
    logic [254:0] p;
    for (int i = 0; i < 128; i++) begin
      ar[i] = a[127-i];
      br[i] = b[127-i];
    end
    p = '0;
    for (int i = 0; i < 128; i++)
      if (br[i]) p ^= {127'b0, ar} << i;
    for (int i = 254; i >= 128; i--)
      if (p[i]) begin
        p[i] = 1'b0;
        p ^= 255'h87 << (i - 128);
      end
    for (int i = 0; i < 128; i++) r[127-i] = p[i];
    return r;
  endfunction

  function automatic logic [0:127] mask_bytes(input logic [0:127] d, input logic [0:15] be);
    logic [0:127] r = d;
    for (int k = 0; k < 16; k++)
      if (!be[k]) r[8*k +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [0:127] model_absorb(input logic [0:2] ph, input logic [0:127] d,
                                                input logic [0:15] be, input logic [0:127] ks);
    if (m_first) begin
      m_y = '0; m_h = i_h; m_ek = i_ek_j0; m_first = 1'b0;
    end
    m_y = gf_mul(m_y ^ mask_bytes(d, be), m_h);
    if (ph == P_TXT) m_data = mask_bytes(d ^ ks, be);
    return m_y ^ m_ek;
  endfunction

  task automatic offer(input logic [0:2] ph, input logic [0:127] d,
                       input logic [0:15] be, input logic [0:127] ks);
    int n = 0;
    @(negedge clk);
    while (!o_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout: got o_ready=0 expected 1");
    end
    i_valid = 1'b1; i_phase = ph; i_data = d; i_byte_en = be; i_keystream = ks;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic do_block(input logic [0:2] ph, input logic [0:127] d, input logic [0:15] be,
                          input logic [0:127] ks, input bit flip);
    logic [0:127] exp_tag;
    exp_tag = model_absorb(ph, d, be, ks);
`ifdef GCM_TAG_CHECK_EN
    if (ph == P_LEN) tb_tag = flip ? (exp_tag ^ 128'h1) : exp_tag;
`endif
    offer(ph, d, be, ks);
    check("data_valid_t1", o_data_valid, (ph == P_TXT));
    check("data_t1", o_data, m_data);
    check("ready_t1", o_ready, 1'b0);
    repeat (127) @(posedge clk);
    #1;
    check("ready_t128", o_ready, 1'b0);
    check("data_valid_t128", o_data_valid, 1'b0);
    check("tag_valid_t128", o_tag_valid, 1'b0);
    @(posedge clk); #1;
    if (ph == P_LEN) begin
      check("tag_valid_t129", o_tag_valid, 1'b1);
      check("tag_t129", o_tag, exp_tag);
`ifdef GCM_TAG_CHECK_EN
      check("auth_ok", o_auth_ok, !flip);
`endif
      m_tag = exp_tag;
      m_first = 1'b1;
      @(posedge clk); #1;
      check("tag_valid_t130", o_tag_valid, 1'b0);
      check("ready_t130", o_ready, 1'b1);
    end else begin
      check("ready_t129", o_ready, 1'b1);
      check("tag_valid_t129_idle", o_tag_valid, 1'b0);
    end
    check("tag_hold", o_tag, m_tag);
  endtask

  task automatic offer_unknown(input logic [0:2] ph);
    offer(ph, {4{$urandom()}}, 16'hFFFF, {4{$urandom()}});
    check("unk_ready", o_ready, 1'b1);
    check("unk_data_valid", o_data_valid, 1'b0);
    check("unk_data_hold", o_data, m_data);
    check("unk_tag_valid", o_tag_valid, 1'b0);
  endtask

  typedef struct {
    logic [0:127] h, ek, txt, len, exp_data, exp_tag;
    logic [0:15]  be;
    bit           has_txt, chk_tag, flip;
  } vec_t;

  localparam logic [0:127] NIST_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] NIST_EK  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [0:127] NIST_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [0:127] NIST_LEN = 128'h00000000000000000000000000000080;
  localparam logic [0:127] NIST_T2  = 128'hab6e47d42cec13bdf53a67b21257bddf;

  initial begin
    vec_t vec[4];
    logic [0:2] unk[5];
    int n_low, n_dv, n_tv;
    logic [0:127] t;

    unk = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b110};
    vec[0] = '{NIST_H, NIST_EK, '0, '0, '0, NIST_EK, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vec[1] = '{NIST_H, NIST_EK, NIST_C, NIST_LEN, '0, NIST_T2, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    vec[2] = '{NIST_H, NIST_EK, NIST_C, NIST_LEN, '0, '0, 16'hFF00, 1'b1, 1'b0, 1'b0};
    vec[3] = '{NIST_H, NIST_EK, NIST_C, NIST_LEN, '0, NIST_T2, 16'hFFFF, 1'b1, 1'b1, 1'b1};

    m_y = '0; m_h = '0; m_ek = '0; m_data = '0; m_tag = '0; m_first = 1'b1;
    rst = 1'b1; i_valid = 1'b0; i_phase = '0; i_data = '0; i_byte_en = '0;
    i_keystream = '0; i_h = '0; i_ek_j0 = '0;
`ifdef GCM_TAG_CHECK_EN
    tb_tag = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", o_ready, 1'b1);
    check("rst_data", o_data, '0);
    check("rst_data_valid", o_data_valid, 1'b0);
    check("rst_tag", o_tag, '0);
    check("rst_tag_valid", o_tag_valid, 1'b0);
`ifdef GCM_TAG_CHECK_EN
    check("rst_auth_ok", o_auth_ok, 1'b0);
`endif

    for (int i = 0; i < 4; i++) begin
      i_h = vec[i].h; i_ek_j0 = vec[i].ek;
      if (vec[i].has_txt) begin
        do_block(P_TXT, vec[i].txt, vec[i].be, vec[i].txt, 1'b0);
        check("vec_data", o_data, vec[i].exp_data);
      end
      do_block(P_LEN, vec[i].len, 16'hFFFF, '0, vec[i].flip);
      if (vec[i].chk_tag) check("vec_tag", o_tag, vec[i].exp_tag);
    end

    // Unknown phase between messages and mid-message must not disturb anything.
    offer_unknown(3'b011);
    i_h = NIST_H; i_ek_j0 = NIST_EK;
    do_block(P_TXT, NIST_C, 16'hFFFF, NIST_C, 1'b0);
    offer_unknown(3'b101);
    do_block(P_LEN, NIST_LEN, 16'hFFFF, '0, 1'b0);
    check("unk_mid_tag", o_tag, NIST_T2);

    // i_valid held high through MULT: exactly one accept.
    void'(model_absorb(P_TXT, NIST_C, 16'hFFFF, NIST_C));
    @(negedge clk);
    i_valid = 1'b1; i_phase = P_TXT; i_data = NIST_C; i_byte_en = 16'hFFFF; i_keystream = NIST_C;
    n_low = 0; n_dv = 0;
    for (int c = 1; c <= 128; c++) begin
      @(negedge clk);
      if (!o_ready) n_low++;
      if (c > 1 && o_data_valid) n_dv++;
    end
    i_valid = 1'b0;
    check("held_ready_low_cycles", n_low, 128);
    check("held_no_second_accept", n_dv, 0);
    @(posedge clk); #1;
    check("held_ready_t129", o_ready, 1'b1);
    do_block(P_LEN, NIST_LEN, 16'hFFFF, '0, 1'b0);
    check("held_tag", o_tag, NIST_T2);

    // Random messages; key inputs are scrambled after the first block.
    for (int m = 0; m < 6; m++) begin
      int n_aad, n_txt;
      n_aad = $urandom_range(0, 2);
      n_txt = $urandom_range(0, 3);
      i_h = {4{$urandom()}}; i_ek_j0 = {4{$urandom()}};
      for (int b = 0; b < n_aad + n_txt; b++) begin
        logic [0:15] be;
        be = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'hFFFF;
        do_block((b < n_aad) ? P_AAD : P_TXT, {4{$urandom()}}, be, {4{$urandom()}}, 1'b0);
        i_h = {4{$urandom()}}; i_ek_j0 = {4{$urandom()}};
        if ($urandom_range(0, 2) == 0) offer_unknown(unk[$urandom_range(0, 4)]);
      end
      do_block(P_LEN, {4{$urandom()}}, 16'hFFFF, '0, bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a length-block multiply.
    i_h = NIST_H; i_ek_j0 = NIST_EK;
    offer(P_LEN, '0, 16'hFFFF, '0);
    repeat (63) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", o_ready, 1'b1);
    check("abort_data", o_data, '0);
    check("abort_data_valid", o_data_valid, 1'b0);
    check("abort_tag", o_tag, '0);
    check("abort_tag_valid", o_tag_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n_tv = 0;
    repeat (140) begin
      @(negedge clk);
      if (o_tag_valid) n_tv++;
    end
    check("abort_no_tag_pulse", n_tv, 0);
    m_first = 1'b1; m_data = '0; m_tag = '0;
    t = NIST_EK;
    do_block(P_LEN, '0, 16'hFFFF, '0, 1'b0);
    check("abort_next_tag", o_tag, t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/gcm_decrypt_stage.md
GCM_DECRYPT_STAGE -- requirements
Module: gcm_decrypt_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: i_valid  in  1  input block offered.
REQ-004 SHALL have: o_ready  out  1  block accepted on clk edge when i_valid && o_ready.
REQ-005 SHALL have: i_phase  in  [0:2]  3'b000 AAD block, 3'b010 ciphertext block, 3'b111 length block; other codes are no-op.
REQ-006 SHALL have: i_data  in  [0:127]  AAD, ciphertext or len(A)||len(C) block.
REQ-007 SHALL have: i_byte_en  in  [0:15]  per-byte valid; byte k covers bits 8k..8k+7.
REQ-008 SHALL have: i_keystream  in  [0:127]  E(K,cb) aligned with the ciphertext block.
REQ-009 SHALL have: i_h  in  [0:127]  hash subkey H.
REQ-010 SHALL have: i_ek_j0  in  [0:127]  E(K,J0).
REQ-011 SHALL have: o_data  out  [0:127]  recovered plaintext; o_data_valid  out  1  qualifier.
REQ-012 SHALL have: o_tag  out  [0:127]  computed tag; o_tag_valid  out  1  one-cycle pulse.

Function
REQ-013 SHALL implement FSM IDLE, MULT, TAG; o_ready = 1 only in IDLE.
REQ-014 SHALL mask i_data bytes with i_byte_en low to zero before any use.
REQ-015 SHALL, on the first accepted block of a message (after reset or after TAG), clear accumulator Y and latch i_h and i_ek_j0 internally.
REQ-016 SHALL, on accepting phase 000/010/111 at edge T, load X = Y ^ masked i_data and enter MULT.
REQ-017 SHALL, for phase 010, register o_data = masked (i_data ^ i_keystream) with o_data_valid = 1 for exactly cycle T+1.
REQ-018 SHALL absorb ciphertext (input), never plaintext, into GHASH.
REQ-019 SHALL compute Y = X * H in GF(2^128) bit-serially, one bit per cycle, bit 0 first: Z ^= V if X[i]; V = V>>1 (toward higher index), XOR 0xE1||0^120 if V[127] was 1.
REQ-020 SHALL run MULT exactly 128 cycles (T+1..T+128) using a 7-bit counter wrapping 127->0 at exit.
REQ-021 SHALL return to IDLE at T+129 for phase 000/010; for phase 111 SHALL enter TAG at T+129.
REQ-022 SHALL, in TAG, drive o_tag = Y ^ latched E(K,J0), o_tag_valid = 1 for one cycle, return to IDLE at T+130 and mark next block as message start.
REQ-023 SHALL hold o_tag stable until next TAG; o_data stable until next text block.
REQ-024 SHALL accept unknown phase codes in IDLE with no state, output or first-block-flag change.
REQ-025 SHALL ignore i_valid while o_ready is low (no buffering, no errors).

Reset
REQ-026 SHALL on rst: state IDLE, counter 0, Y/X/Z/V/latched H/latched EK(J0) = 0, first-block flag = 1.
REQ-027 SHALL reset outputs: o_ready = 1 after reset release, o_data = 0, o_data_valid = 0, o_tag = 0, o_tag_valid = 0.
REQ-028 SHALL abort any in-flight MULT or TAG on rst assertion with no tag pulse.

Configuration
REQ-029 SHALL, with GCM_TAG_CHECK_EN defined, add i_tag  in  [0:127] and o_auth_ok  out  1; o_auth_ok = (o_tag == i_tag sampled at length-block accept), valid with o_tag_valid, reset 0.
REQ-030 SHALL, without GCM_TAG_CHECK_EN, omit i_tag and o_auth_ok; all other behaviour unchanged.

Verification
REQ-031 NIST case 1: H=66e94bd4ef8a2c3b884cfa59ca342b2e, EK(J0)=58e2fccefa7e3061367f1d57a4e7455a, length block 0 -> o_tag=58e2fccefa7e3061367f1d57a4e7455a at T+129.
REQ-032 NIST case 2: text 0388dace60b6a392f328c2b971b2fe78, keystream same -> o_data=0 at T+1; length block 0...0080 -> o_tag=ab6e47d42cec13bdf53a67b21257bddf.
REQ-033 Case 2 with i_byte_en=16'hFF00 -> o_data=0, GHASH absorbs only bytes 0-7; tag matches software model.
REQ-034 i_valid held high during MULT -> o_ready low 128 cycles, no second accept; phase 011 in IDLE -> no output, no state change.
REQ-035 rst asserted at T+64 of length-block MULT -> no o_tag_valid, all outputs 0, next message yields correct case-1 tag.
REQ-036 With GCM_TAG_CHECK_EN: case 2 with i_tag correct -> o_auth_ok=1; one bit flipped -> o_auth_ok=0.
